imm_extend_pipe: RTL and testbench
==================================

# imm_extend_pipe

Registered, parametrised successor to the decode-stage immediate extender. It accepts an instruction word and an immediate-format select through a valid/ready handshake, and generates the sign-extended XLEN-bit immediate. The result goes into a small in-order output FIFO, so decode and execute can stall independently. It sits between fetch/decode and the execute-stage operand mux in the pipelined core, and carries a per-instruction tag (e.g. PC bits) alongside each immediate.

## Interface
- XLEN, 32, immediate output width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, ≥ 2.
- TAG_W, 8, width of the sideband tag carried with each immediate.

- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset; one clock domain.
- flush  in  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  25  instruction bits [31:7].
- in_imm_src  in  3  format select: 000 I, 001 S, 010 B, 011 J, 100 U, 101 CSR-zimm (macro-gated), 110/111 illegal.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_imm  out  XLEN  extended immediate.
- out_tag  out  TAG_W  tag of head entry.
- out_err  out  1  head entry had an illegal format select.

## Operation
- Push when in_valid && in_ready: decode immediate combinationally; write {imm, tag, err} at wptr; wptr increments.
- Pop when out_valid && out_ready: rptr increments.
- in_ready = (count != DEPTH). It does not depend on out_ready; when full, a push is refused even if a pop occurs in the same cycle.
- out_valid = (count != 0). When out_valid=0, out_imm, out_tag and out_err are driven to 0.
- Formats (s = instr[31]; sext means sign-extend to XLEN from bit 31):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - U: sext({instr[31:12], 12'b0}).
- Illegal select: imm = 0, err = 1, entry still pushed in order.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Simultaneous push and pop: count unchanged, both pointers advance.

## Timing
- Latency is 1 cycle: an entry pushed at edge N is visible on out_* after edge N.
- Throughput is 1 per cycle while not full.
- Reset (rst=1 at edge): count=0, wptr=rptr=0, out_valid=0, in_ready=1, out_* = 0. rst asserted mid-operation drops all entries.
- Priority: rst > flush > push/pop.
  - A flush cycle resets count and pointers to 0.
  - A push or pop in the flush cycle is discarded.
  - in_ready stays 1 during flush.
- FIFO storage is not reset; only control state is.

## Configuration
- IMM_EXTEND_ZICSR_EN defined: select 101 yields zero-extended instr[19:15] (CSR uimm), with err=0.
- Not defined: select 101 is illegal (imm=0, err=1).

## Structure
- Package imm_pkg holds:
  - imm_src_e enum (3-bit, encodings above).
  - IMM_SRC_W = 3.
  - Packed struct imm_entry_t {imm, tag, err}, parametrised via the module.
- Sub-module imm_decode: purely combinational. Inputs are instr, imm_src and XLEN; outputs are imm and err. The macro is handled here.
- The FIFO and handshake live in imm_extend_pipe.

## Test plan
- Basic formats, XLEN=32, default depth:
  - I, instr 0xFFF00093 (addi x1,x0,-1) → out_imm 0xFFFFFFFF one cycle later, err 0.
  - U, 0x123450B7 → 0x12345000.
  - S, 0xFE112E23 (sw x1,-4(x2)) → 0xFFFFFFFC.
- B-type at both widths: 0xFE000EE3 (beq -4) → 0xFFFFFFFC at XLEN=32; 0xFFFFFFFFFFFFFFFC at XLEN=64. J, 0x0080006F (jal +8) → 0x00000008.
- Backpressure, DEPTH=4:
  - Hold out_ready=0 and push tags 1..4 → in_ready=0 after the 4th accept; push with tag 5 held off.
  - Raise out_ready → tags 1,2,3,4 pop in order, one per cycle; tag 5 is accepted the cycle after count drops below 4.
- Flush: with 2 entries buffered, assert flush together with in_valid=1 and out_ready=1 → next cycle out_valid=0, count 0, no entry popped or pushed.
- Reset mid-stream: rst with 3 entries buffered → out_valid=0, out_imm 0, in_ready=1 next cycle; a fresh push has latency 1.
- Illegal/CSR selects:
  - Select 111 → out_imm 0, out_err 1, FIFO order preserved.
  - Select 101 with rs1 field 5'b10101: with IMM_EXTEND_ZICSR_EN → 0x00000015, err 0; without the macro → 0, err 1.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the pipelined immediate extender: format-select encodings.
// The struct carried per FIFO entry depends on XLEN/TAG_W and is declared in imm_extend_pipe.
package imm_pkg;

    localparam int IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I    = 3'b000,
        IMM_S    = 3'b001,
        IMM_B    = 3'b010,
        IMM_J    = 3'b011,
        IMM_U    = 3'b100,
        IMM_CSR  = 3'b101,
        IMM_RSV6 = 3'b110,
        IMM_RSV7 = 3'b111
    } imm_src_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: rebuilds the I/S/B/J/U immediates and sign-extends to XLEN.
// Define IMM_EXTEND_ZICSR_EN to make select 101 return the zero-extended CSR uimm field.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]           instr,
    input  logic [IMM_SRC_W-1:0]  imm_src,
    output logic [XLEN-1:0]       imm,
    output logic                  err
);

    // Re-index the incoming slice with its architectural bit numbers.
    logic [31:7] ins;
    logic [31:0] imm32;

    assign ins = instr;

    always_comb begin
        imm32 = '0;
        err   = 1'b0;
        case (imm_src_e'(imm_src))
            IMM_I:   imm32 = {{20{ins[31]}}, ins[31:20]};
            IMM_S:   imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B:   imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            IMM_J:   imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            IMM_U:   imm32 = {ins[31:12], 12'b0};
`ifdef IMM_EXTEND_ZICSR_EN
            IMM_CSR: imm32 = {27'b0, ins[19:15]};
`else
            IMM_CSR: err = 1'b1;
`endif
            default: err = 1'b1;
        endcase
    end

    // Every format is sign-extended from bit 31; the CSR uimm has bit 31 clear.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extender: decodes on push and queues {imm, tag, err} in an in-order FIFO.
// Optional CSR uimm support is selected by IMM_EXTEND_ZICSR_EN (handled in imm_decode).
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [24:0]           in_instr,
    input  logic [IMM_SRC_W-1:0]  in_imm_src,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_imm,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } imm_entry_t;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    imm_entry_t       mem_q [DEPTH];
    imm_entry_t       wr_entry;
    imm_entry_t       head;

    logic [XLEN-1:0]  dec_imm;
    logic             dec_err;
    logic             push;
    logic             pop;

    imm_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (dec_imm),
        .err     (dec_err)
    );

    // A full FIFO refuses a push even when the head pops in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_entry     = '0;
        wr_entry.imm = dec_imm;
        wr_entry.tag = in_tag;
        wr_entry.err = dec_err;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage holds no reset; only writes that actually commit are let through.
    always_ff @(posedge clk) begin
        if (push && !flush && !rst) begin
            mem_q[wptr_q] <= wr_entry;
        end
    end

    assign head    = mem_q[rptr_q];
    assign out_imm = out_valid ? head.imm : '0;
    assign out_tag = out_valid ? head.tag : '0;
    assign out_err = out_valid ? head.err : 1'b0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: two DUTs (XLEN=32 and XLEN=64, DEPTH=4) share stimulus and are checked
// every cycle against a queue-based reference model, plus directed checks with literal values.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_instr;
    logic [2:0]  in_imm_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        rdy_a, val_a, err_a;
    logic [31:0] imm_a;
    logic [7:0]  tag_a;
    logic        rdy_b, val_b, err_b;
    logic [63:0] imm_b;
    logic [7:0]  tag_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } ent_t;

    ent_t model_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.XLEN(32), .DEPTH(4), .TAG_W(8)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_a), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(val_a), .out_ready(out_ready),
        .out_imm(imm_a), .out_tag(tag_a), .out_err(err_a)
    );

    imm_extend_pipe #(.XLEN(64), .DEPTH(4), .TAG_W(8)) dut_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy_b), .in_instr(in_instr),
        .in_imm_src(in_imm_src), .in_tag(in_tag),
        .out_valid(val_b), .out_ready(out_ready),
        .out_imm(imm_b), .out_tag(tag_b), .out_err(err_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference immediate from the RISC-V field definitions using plain integer arithmetic.
    function automatic void ref_imm(input logic [31:0] w, input logic [2:0] src,
                                    output logic [63:0] imm, output logic err);
        longint sw;
        longint r;
        sw  = longint'($signed(w));
        r   = 0;
        err = 1'b0;
        case (src)
            3'd0: r = sw >>> 20;
            3'd1: r = ((sw >>> 25) <<< 5) | ((sw >> 7) & 31);
            3'd2: r = (w[31] ? longint'(-4096) : 0) + (((sw >> 7) & 1) << 11)
                      + (((sw >> 25) & 63) << 5) + (((sw >> 8) & 15) << 1);
            3'd3: r = (w[31] ? longint'(-1048576) : 0) + (((sw >> 12) & 255) << 12)
                      + (((sw >> 20) & 1) << 11) + (((sw >> 21) & 1023) << 1);
            3'd4: r = sw & ~longint'(4095);
`ifdef IMM_EXTEND_ZICSR_EN
            3'd5: r = (sw >> 15) & 31;
`else
            3'd5: err = 1'b1;
`endif
            default: err = 1'b1;
        endcase
        imm = r;
    endfunction

    // One clock: apply inputs at negedge, check outputs against the model, then advance the model.
    task automatic cyc(input logic v, input logic [31:0] w, input logic [2:0] src,
                       input logic [7:0] tg, input logic ordy, input logic fl, input logic rs);
        ent_t e;
        logic do_push;
        logic do_pop;
        in_valid   = v;
        in_instr   = w[31:7];
        in_imm_src = src;
        in_tag     = tg;
        out_ready  = ordy;
        flush      = fl;
        rst        = rs;
        chk("valid_a", {63'd0, val_a}, {63'd0, model_q.size() != 0});
        chk("ready_a", {63'd0, rdy_a}, {63'd0, model_q.size() != 4});
        chk("valid_b", {63'd0, val_b}, {63'd0, model_q.size() != 0});
        if (model_q.size() != 0) begin
            chk("imm_a", {32'd0, imm_a}, {32'd0, model_q[0].imm[31:0]});
            chk("imm_b", imm_b, model_q[0].imm);
            chk("tag_a", {56'd0, tag_a}, {56'd0, model_q[0].tag});
            chk("err_a", {63'd0, err_a}, {63'd0, model_q[0].err});
            chk("err_b", {63'd0, err_b}, {63'd0, model_q[0].err});
        end else begin
            chk("idle_imm_a", {32'd0, imm_a}, 64'd0);
            chk("idle_imm_b", imm_b, 64'd0);
            chk("idle_tag", {56'd0, tag_a}, 64'd0);
            chk("idle_err", {63'd0, err_a}, 64'd0);
        end
        do_push = v && (model_q.size() != 4);
        do_pop  = ordy && (model_q.size() != 0);
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                $display("pop  tag=%0d imm=0x%0h err=%0b", model_q[0].tag, model_q[0].imm, model_q[0].err);
                void'(model_q.pop_front());
            end
            if (do_push) begin
                ref_imm(w, src, e.imm, e.err);
                e.tag = tg;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 3'd0, 8'd0, 1'b1, 1'b0, 1'b0);
    endtask

    // Push one instruction into an empty FIFO and check the literal result one cycle later.
    task automatic push_one(input string name, input logic [31:0] w, input logic [2:0] src,
                            input logic [7:0] tg, input logic [31:0] e32, input logic [63:0] e64,
                            input logic eerr);
        cyc(1'b1, w, src, tg, 1'b0, 1'b0, 1'b0);
        chk({name, "_valid"}, {63'd0, val_a}, 64'd1);
        chk({name, "_imm32"}, {32'd0, imm_a}, {32'd0, e32});
        chk({name, "_imm64"}, imm_b, e64);
        chk({name, "_err"}, {63'd0, err_a}, {63'd0, eerr});
        chk({name, "_tag"}, {56'd0, tag_b}, {56'd0, tg});
        idle(1);
    endtask

    initial begin
        logic [31:0] csr_e32;
        logic        csr_err;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        in_imm_src = '0; in_tag = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_valid", {63'd0, val_a}, 64'd0);
        chk("rst_ready", {63'd0, rdy_a}, 64'd1);
        chk("rst_imm", imm_b, 64'd0);

        push_one("I", 32'hFFF00093, 3'd0, 8'd1, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        push_one("U", 32'h123450B7, 3'd4, 8'd2, 32'h12345000, 64'h0000000012345000, 1'b0);
        push_one("S", 32'hFE112E23, 3'd1, 8'd3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        push_one("B", 32'hFE000EE3, 3'd2, 8'd4, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
        push_one("J", 32'h0080006F, 3'd3, 8'd5, 32'h00000008, 64'h0000000000000008, 1'b0);
        push_one("ILL7", 32'hFFF00093, 3'd7, 8'd6, 32'h0, 64'h0, 1'b1);
`ifdef IMM_EXTEND_ZICSR_EN
        csr_e32 = 32'h15; csr_err = 1'b0;
`else
        csr_e32 = 32'h0;  csr_err = 1'b1;
`endif
        push_one("CSR", 32'h000A8073, 3'd5, 8'd7, csr_e32, {32'd0, csr_e32}, csr_err);

        // Backpressure: fill all four entries, then the fifth must wait for a slot.
        for (int k = 1; k <= 4; k++) cyc(1'b1, 32'h0080006F, 3'd3, 8'(k), 1'b0, 1'b0, 1'b0);
        chk("full_ready", {63'd0, rdy_a}, 64'd0);
        cyc(1'b1, 32'h0080006F, 3'd3, 8'd5, 1'b0, 1'b0, 1'b0);
        chk("held_off_ready", {63'd0, rdy_b}, 64'd0);
        for (int k = 1; k <= 5; k++) begin
            chk("drain_tag", {56'd0, tag_a}, 64'(k));
            cyc(k <= 2, 32'h0080006F, 3'd3, 8'd5, 1'b1, 1'b0, 1'b0);
        end
        chk("drained", {63'd0, val_a}, 64'd0);

        // Illegal entry stays in order between legal ones.
        cyc(1'b1, 32'hFFF00093, 3'd0, 8'd10, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h123450B7, 3'd7, 8'd11, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h123450B7, 3'd4, 8'd12, 1'b0, 1'b0, 1'b0);
        chk("ord_tag0", {56'd0, tag_a}, 64'd10);
        idle(1);
        chk("ord_tag1", {56'd0, tag_a}, 64'd11);
        chk("ord_err1", {63'd0, err_a}, 64'd1);
        chk("ord_imm1", imm_b, 64'd0);
        idle(1);
        chk("ord_tag2", {56'd0, tag_a}, 64'd12);
        chk("ord_imm2", {32'd0, imm_a}, 64'h12345000);
        idle(1);

        // Flush with push and pop requested in the same cycle.
        cyc(1'b1, 32'hFFF00093, 3'd0, 8'd20, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFF00093, 3'd0, 8'd21, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFF00093, 3'd0, 8'd22, 1'b1, 1'b1, 1'b0);
        chk("flush_valid", {63'd0, val_a}, 64'd0);
        chk("flush_ready", {63'd0, rdy_a}, 64'd1);
        chk("flush_imm", imm_b, 64'd0);

        // Reset mid-stream, then a fresh push must appear after one edge.
        for (int k = 0; k < 3; k++) cyc(1'b1, 32'h123450B7, 3'd4, 8'(30 + k), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_valid", {63'd0, val_b}, 64'd0);
        chk("rst_mid_imm", {32'd0, imm_a}, 64'd0);
        chk("rst_mid_ready", {63'd0, rdy_a}, 64'd1);
        cyc(1'b1, 32'hFE112E23, 3'd1, 8'd40, 1'b0, 1'b0, 1'b0);
        chk("rst_fresh_valid", {63'd0, val_a}, 64'd1);
        chk("rst_fresh_imm", {32'd0, imm_a}, 64'hFFFFFFFC);
        idle(2);

        // Random traffic checked against the model every cycle.
        for (int n = 0; n < 400; n++) begin
            cyc($urandom_range(0, 3) != 0, $urandom(), 3'($urandom_range(0, 7)),
                8'($urandom()), $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0, $urandom_range(0, 80) == 0);
        end
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
